// File: rtl/uart_hex_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_hex_pkg
// Description : Shared types, character constants and the nibble-to-ASCII
//               helper used by the hex line encoder.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package uart_hex_pkg;

   // Word tag carried in the two MSBs of every input word
   typedef enum logic [1:0] {
      TAG_RD  = 2'b00,
      TAG_ACK = 2'b01,
      TAG_ADR = 2'b10,
      TAG_ERR = 2'b11
   } tag_t;

   // Line-level sequencer: which character of the line is being sent
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_PREFIX = 3'd2,
      ST_DIGIT  = 3'd3,
      ST_CR     = 3'd4,
      ST_LF     = 3'd5
   } line_state_t;

   // Per-character UART handshake phase
   typedef enum logic [1:0] {
      S_GO  = 2'd0,
      S_ACK = 2'd1,
      S_END = 2'd2
   } hs_state_t;

   localparam logic [7:0] CH_R  = 8'h52;
   localparam logic [7:0] CH_A  = 8'h41;
   localparam logic [7:0] CH_K  = 8'h4B;
   localparam logic [7:0] CH_E  = 8'h45;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;

   // Map one nibble to its ASCII hex digit, lower or upper case letters
   function automatic logic [7:0] nib2hex(input logic [3:0] nib, input logic lower);
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end
      return (lower ? 8'h61 : 8'h41) + {4'h0, nib} - 8'd10;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_hex_encoder_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with first-word fall-through read data.
//               A push while full is honoured when a pop happens in the same
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int unsigned W  = 8,
   parameter int unsigned LG = 2
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty
);

   localparam int unsigned DEPTH = 1 << LG;

   logic [W-1:0] mem_q [DEPTH];
   logic [LG:0]  wr_q;
   logic [LG:0]  rd_q;
   logic         w_do_push;
   logic         w_do_pop;

   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (w_do_push) wr_q <= wr_q + (LG+1)'(1);
         if (w_do_pop)  rd_q <= rd_q + (LG+1)'(1);
      end
   end

   // Storage array; contents need no reset because the pointers gate them
   always_ff @(posedge i_clk) begin
      if (w_do_push) mem_q[wr_q[LG-1:0]] <= i_wdata;
   end

   assign o_rdata = mem_q[rd_q[LG-1:0]];
   assign o_empty = (wr_q == rd_q);
   assign o_full  = (wr_q[LG] != rd_q[LG]) && (wr_q[LG-1:0] == rd_q[LG-1:0]);

endmodule
`default_nettype wire

// File: rtl/uart_hex_encoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_hex_encoder
// Description : Converts tagged bus result words into ASCII text lines
//               (prefix char, MSB-first hex digits, optional CR LF) and
//               feeds them one character at a time to a UART transmitter.
// Revision    : 1.0 - parametrised width/case/newline successor release
// ============================================================================
module uart_hex_encoder
   import uart_hex_pkg::*;
#(
   parameter int unsigned DW      = 32,
   parameter int unsigned FIFO_LG = 2,
   parameter bit          NEWLINE = 1'b1,
   parameter bit          LOWER   = 1'b1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_stb,
   input  logic [DW+1:0] i_word,
   output logic          o_busy,
   output logic [7:0]    o_dropped,
   output logic [7:0]    o_tx_data,
   output logic          o_tx_start,
   input  logic          i_tx_busy,
   output logic          o_idle
);

   localparam int unsigned ND = (DW + 3) / 4;
   localparam int unsigned SW = ND * 4;
   localparam int unsigned CW = $clog2(ND + 1);

   line_state_t   state_q, state_d;
   hs_state_t     hs_q, hs_d;
   tag_t          tag_q, tag_d;
   logic [SW-1:0] shift_q, shift_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    txd_q, txd_d;
   logic [7:0]    dropped_q;

   logic          w_push, w_pop, w_full, w_empty;
   logic [DW+1:0] w_head;
   logic [SW-1:0] w_load;
   logic [7:0]    w_char;
   logic          w_start, w_adv, w_is_char;

   // A pop only happens in LOAD, so a push into a full FIFO is let through then
   assign w_pop  = (state_q == ST_LOAD);
   assign o_busy = w_full & ~w_pop;
   assign w_push = i_stb & ~o_busy;

   sync_fifo #(
      .W  (DW + 2),
      .LG (FIFO_LG)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_wdata (i_word),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Saturating count of words offered while the FIFO could not take them
   always_ff @(posedge i_clk) begin
      if (i_reset)                              dropped_q <= 8'h00;
      else if (i_stb && o_busy && dropped_q != 8'hFF) dropped_q <= dropped_q + 8'd1;
   end

   assign w_is_char = (state_q == ST_PREFIX) || (state_q == ST_DIGIT) ||
                      (state_q == ST_CR)     || (state_q == ST_LF);

   // Line sequencer and character handshake next-state logic
   always_comb begin
      state_d = state_q;
      hs_d    = hs_q;
      tag_d   = tag_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      txd_d   = txd_q;
      w_char  = 8'h00;
      w_start = 1'b0;
      w_adv   = 1'b0;
      w_load  = '0;
      w_load[DW-1:0] = w_head[DW-1:0];

      case (state_q)
         ST_PREFIX: begin
            case (tag_q)
               TAG_RD:  w_char = CH_R;
               TAG_ADR: w_char = CH_A;
               TAG_ACK: w_char = CH_K;
               default: w_char = CH_E;
            endcase
         end
         ST_DIGIT: w_char = nib2hex(shift_q[SW-1 -: 4], LOWER);
         ST_CR:    w_char = CH_CR;
         ST_LF:    w_char = CH_LF;
         default:  w_char = 8'h00;
      endcase

      // Every character waits for an idle UART, pulses, then sees busy rise and fall
      if (w_is_char) begin
         case (hs_q)
            S_GO: begin
               if (!i_tx_busy) begin
                  w_start = 1'b1;
                  txd_d   = w_char;
                  hs_d    = S_ACK;
               end
            end
            S_ACK: begin
               if (i_tx_busy) hs_d = S_END;
            end
            default: begin
               if (!i_tx_busy) begin
                  w_adv = 1'b1;
                  hs_d  = S_GO;
               end
            end
         endcase
      end

      case (state_q)
         ST_IDLE: begin
            if (!w_empty) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            tag_d   = tag_t'(w_head[DW+1:DW]);
            shift_d = w_load;
            cnt_d   = CW'(ND);
            hs_d    = S_GO;
            state_d = ST_PREFIX;
         end
         ST_PREFIX: begin
            if (w_adv) begin
               if (tag_q == TAG_RD || tag_q == TAG_ADR) state_d = ST_DIGIT;
               else                                     state_d = NEWLINE ? ST_CR : ST_IDLE;
            end
         end
         ST_DIGIT: begin
            if (w_adv) begin
               shift_d = shift_q << 4;
               cnt_d   = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = NEWLINE ? ST_CR : ST_IDLE;
            end
         end
         ST_CR: begin
            if (w_adv) state_d = ST_LF;
         end
         ST_LF: begin
            if (w_adv) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer registers; reset abandons any line in progress
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         hs_q    <= S_GO;
         tag_q   <= TAG_RD;
         shift_q <= '0;
         cnt_q   <= '0;
         txd_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         hs_q    <= hs_d;
         tag_q   <= tag_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         txd_q   <= txd_d;
      end
   end

   // The new character shows during its pulse and is held until the next one
   assign o_tx_data  = w_start ? w_char : txd_q;
   assign o_tx_start = w_start;
   assign o_dropped  = dropped_q;
   assign o_idle     = w_empty & (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_hex_encoder
// Description : Self-checking bench for uart_hex_encoder with a reactive
//               UART model and an expected-character scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_hex_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        stb;
   logic [33:0] word;
   logic        busy_o;
   logic [7:0]  dropped;
   logic [7:0]  txd;
   logic        txs;
   logic        tx_busy;
   logic        idle;
   logic        stall;
   logic        mbusy;

   logic        stb2;
   logic [11:0] word2;
   logic        busy2_o;
   logic [7:0]  dropped2;
   logic [7:0]  txd2;
   logic        txs2;
   logic        busy2;
   logic        idle2;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] exp2[$];
   logic [7:0] got2[$];
   int         rcv_cnt = 0;
   int         mph = 0;
   int         mcnt = 0;
   bit         rnd_mode = 1'b0;
   int         b2 = 0;

   always #5 clk = ~clk;

   assign tx_busy = stall | mbusy;

   uart_hex_encoder #(.DW(32), .FIFO_LG(2), .NEWLINE(1'b1), .LOWER(1'b1)) dut (
      .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_word(word), .o_busy(busy_o),
      .o_dropped(dropped), .o_tx_data(txd), .o_tx_start(txs), .i_tx_busy(tx_busy),
      .o_idle(idle));

   uart_hex_encoder #(.DW(10), .FIFO_LG(2), .NEWLINE(1'b0), .LOWER(1'b0)) dut2 (
      .i_clk(clk), .i_reset(rst), .i_stb(stb2), .i_word(word2), .o_busy(busy2_o),
      .o_dropped(dropped2), .o_tx_data(txd2), .o_tx_start(txs2), .i_tx_busy(busy2),
      .o_idle(idle2));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference line builder: prefix, 8 MSB-first hex digits for data tags, CR LF
   function automatic void push_line(input logic [33:0] w);
      string      hx;
      logic [3:0] nb;
      hx = "0123456789abcdef";
      case (w[33:32])
         2'b00:   exp_q.push_back(8'h52);
         2'b10:   exp_q.push_back(8'h41);
         2'b01:   exp_q.push_back(8'h4B);
         default: exp_q.push_back(8'h45);
      endcase
      if (!w[32]) begin
         for (int i = 7; i >= 0; i--) begin
            nb = w[4*i +: 4];
            exp_q.push_back(hx[nb]);
         end
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endfunction

   // UART model for the main DUT: checks each started char against the scoreboard
   initial begin
      mbusy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mbusy = 1'b0;
            mph   = 0;
         end else begin
            if (txs && tx_busy) chk("start while busy", 64'd1, 64'd0);
            if (txs && mph != 0) chk("start during handshake", 64'd1, 64'd0);
            case (mph)
               0: begin
                  if (txs) begin
                     rcv_cnt++;
                     if (exp_q.size() == 0) chk("unexpected start", 64'(txd), 64'h100);
                     else chk("char", 64'(txd), 64'(exp_q.pop_front()));
                     mcnt = rnd_mode ? int'($urandom_range(0, 3)) : 0;
                     mph  = 1;
                  end
               end
               1: begin
                  if (mcnt == 0) begin
                     mbusy = 1'b1;
                     mcnt  = rnd_mode ? int'($urandom_range(0, 3)) : 0;
                     mph   = 2;
                  end else mcnt--;
               end
               default: begin
                  if (mcnt == 0) begin
                     mbusy = 1'b0;
                     mph   = 0;
                  end else mcnt--;
               end
            endcase
         end
      end
   end

   // Simple fixed-timing UART model for the narrow DUT
   initial begin
      busy2 = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy2 = 1'b0;
            b2    = 0;
         end else if (b2 == 1) begin
            busy2 = 1'b1;
            b2    = 2;
         end else if (b2 == 2) begin
            busy2 = 1'b0;
            b2    = 0;
         end else if (txs2) begin
            got2.push_back(txd2);
            b2 = 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [33:0] w, input bit expect_it);
      int n = 0;
      while (busy_o && n < 500) begin
         tick();
         n++;
      end
      if (expect_it) push_line(w);
      stb  = 1'b1;
      word = w;
      tick();
      stb  = 1'b0;
   endtask

   task automatic wait_done(input string name, input int maxc);
      int n = 0;
      while (!(idle && mph == 0 && exp_q.size() == 0) && n < maxc) begin
         tick();
         n++;
      end
      chk({name, " complete"}, 64'(idle && mph == 0 && exp_q.size() == 0), 64'd1);
   endtask

   typedef struct {
      logic [33:0] w;
      int          n;
      logic [87:0] c;
   } vec_t;

   vec_t        tv [6];
   logic [33:0] wb [6];

   initial begin
      int          base;
      int          n;
      logic [1:0]  tg;
      logic [33:0] w;

      tv[0] = '{{2'b00, 32'h000012AB}, 11,
                {8'h52, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h32, 8'h61, 8'h62, 8'h0D, 8'h0A}};
      tv[1] = '{{2'b01, 32'hFFFFFFFF}, 3, {8'h4B, 8'h0D, 8'h0A, 64'h0}};
      tv[2] = '{{2'b11, 32'h00000000}, 3, {8'h45, 8'h0D, 8'h0A, 64'h0}};
      tv[3] = '{{2'b10, 32'hDEADBEEF}, 11,
                {8'h41, 8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0D, 8'h0A}};
      tv[4] = '{{2'b00, 32'h00000000}, 11,
                {8'h52, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A}};
      tv[5] = '{{2'b10, 32'h9876FEDC}, 11,
                {8'h41, 8'h39, 8'h38, 8'h37, 8'h36, 8'h66, 8'h65, 8'h64, 8'h63, 8'h0D, 8'h0A}};

      wb[0] = {2'b00, 32'h11111111};
      wb[1] = {2'b01, 32'h22222222};
      wb[2] = {2'b10, 32'h33333333};
      wb[3] = {2'b11, 32'h44444444};
      wb[4] = {2'b00, 32'h55555555};
      wb[5] = {2'b10, 32'h66666666};

      rst = 1'b1; stb = 1'b0; word = '0; stall = 1'b0;
      stb2 = 1'b0; word2 = '0;
      repeat (3) tick();

      // Reset state
      chk("reset o_busy",     64'(busy_o),  64'd0);
      chk("reset o_dropped",  64'(dropped), 64'd0);
      chk("reset o_tx_data",  64'(txd),     64'd0);
      chk("reset o_tx_start", 64'(txs),     64'd0);
      chk("reset o_idle",     64'(idle),    64'd1);
      rst = 1'b0;
      tick();

      // Table vectors, first one also checks start latency and data hold
      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < tv[v].n; k++) exp_q.push_back(tv[v].c[87 - 8*k -: 8]);
         send(tv[v].w, 1'b0);
         if (v == 0) begin
            chk("latency N",   64'(txs), 64'd0);
            tick();
            chk("latency N+1", 64'(txs), 64'd0);
            tick();
            chk("latency N+2", 64'(txs), 64'd1);
            chk("first char",  64'(txd), 64'h52);
            tick();
            chk("char hold",   64'(txd), 64'h52);
         end
         wait_done("vector", 400);
      end

      // Narrow, upper-case, no-newline instance
      exp2.push_back(8'h41); exp2.push_back(8'h33);
      exp2.push_back(8'h46); exp2.push_back(8'h46);
      stb2 = 1'b1; word2 = {2'b10, 10'h3FF};
      tick();
      stb2 = 1'b0;
      n = 0;
      while ((got2.size() < 4 || !idle2) && n < 200) begin
         tick();
         n++;
      end
      for (int i = 0; i < 4; i++) begin
         if (got2.size() == 0) chk("dut2 missing char", 64'd0, 64'd1);
         else chk("dut2 char", 64'(got2.pop_front()), 64'(exp2.pop_front()));
      end
      repeat (5) tick();
      chk("dut2 no extra chars", 64'(got2.size()), 64'd0);

      // Overflow: line stalled on the UART, burst of six words into a depth-4 FIFO
      stall = 1'b1;
      send({2'b10, 32'h0BADF00D}, 1'b1);
      repeat (5) tick();
      base = rcv_cnt;
      chk("stalled no start", 64'(rcv_cnt - base + int'(txs)), 64'd0);
      for (int i = 0; i < 6; i++) begin
         if (i < 4) push_line(wb[i]);
         stb  = 1'b1;
         word = wb[i];
         tick();
         chk("burst o_busy", 64'(busy_o), (i >= 3) ? 64'd1 : 64'd0);
      end
      stb = 1'b0;
      chk("burst o_dropped", 64'(dropped), 64'd2);
      stall = 1'b0;
      wait_done("burst", 2000);

      // Random words with a UART that answers after 0..3 cycles
      rnd_mode = 1'b1;
      for (int i = 0; i < 25; i++) begin
         tg = 2'($urandom_range(0, 3));
         w  = {tg, 32'($urandom())};
         send(w, 1'b1);
         repeat ($urandom_range(0, 6)) tick();
      end
      wait_done("random", 6000);
      rnd_mode = 1'b0;

      // Reset after the third character of a line
      base = rcv_cnt;
      send({2'b00, 32'hCAFE1234}, 1'b1);
      n = 0;
      while (rcv_cnt < base + 3 && n < 200) begin
         tick();
         n++;
      end
      chk("three chars before reset", 64'(rcv_cnt - base), 64'd3);
      rst = 1'b1;
      exp_q.delete();
      base = rcv_cnt;
      tick();
      tick();
      rst = 1'b0;
      repeat (15) tick();
      chk("no start after reset", 64'(rcv_cnt - base), 64'd0);
      chk("idle after reset",     64'(idle),    64'd1);
      chk("dropped cleared",      64'(dropped), 64'd0);
      chk("tx_data cleared",      64'(txd),     64'd0);
      send({2'b10, 32'h01234567}, 1'b1);
      wait_done("post-reset line", 400);

      // After reset with the UART busy, the first start waits for it
      stall = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      base = rcv_cnt;
      send({2'b11, 32'h00000001}, 1'b1);
      repeat (10) tick();
      chk("wait for idle uart", 64'(rcv_cnt - base + int'(txs)), 64'd0);
      stall = 1'b0;
      wait_done("busy-after-reset line", 400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
